// File: rtl/text_writer.sv
// text_writer: write-side client of the dual-port text framebuffer.
// Takes ASCII bytes on a valid/ready stream, tracks a character cursor and
// issues framebuffer writes, blanking the whole screen after reset or a form feed.
//
// Handshake: a byte is transferred on a rising clk edge where in_valid and
// in_ready are both high. in_ready is a registered output that is high only in
// IDLE, so one byte per cycle can be taken. A source that sees in_ready low must
// hold in_valid and in_data until the transfer happens. in_data is ignored while
// in_valid is low.
module text_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int data_width = 8,
  parameter int ram_size = COLS * ROWS,
  parameter int addr_width = $clog2(ram_size),
  parameter logic [data_width-1:0] BLANK = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [data_width-1:0]     in_data,
  output logic                      in_ready,
  output logic                      write_en,
  output logic [addr_width-1:0]     waddr,
  output logic [data_width-1:0]     din,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row
);

  localparam int col_w = $clog2(COLS);
  localparam int row_w = $clog2(ROWS);

  localparam logic [col_w-1:0]      LAST_COL  = col_w'(COLS - 1);
  localparam logic [row_w-1:0]      LAST_ROW  = row_w'(ROWS - 1);
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(ram_size - 1);
  localparam logic [addr_width-1:0] COLS_A    = addr_width'(COLS);
  localparam logic [addr_width-1:0] ONE_A     = addr_width'(1);
  localparam logic [col_w-1:0]      ONE_C     = col_w'(1);
  localparam logic [row_w-1:0]      ONE_R     = row_w'(1);

  localparam logic [data_width-1:0] CH_BS    = data_width'(8'h08);
  localparam logic [data_width-1:0] CH_LF    = data_width'(8'h0A);
  localparam logic [data_width-1:0] CH_FF    = data_width'(8'h0C);
  localparam logic [data_width-1:0] CH_CR    = data_width'(8'h0D);
  localparam logic [data_width-1:0] CH_FIRST = data_width'(8'h20);
  localparam logic [data_width-1:0] CH_LAST  = data_width'(8'h7E);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Visible by hierarchical name for checkers that want to follow the FSM.
  state_t                state;
  logic [addr_width-1:0] clr_cnt;
  // Linear framebuffer address of the cursor, kept equal to row*COLS+col.
  logic [addr_width-1:0] cur_addr;
  logic [col_w-1:0]      col;
  logic [row_w-1:0]      row;

  logic accept;
  logic printable;
  logic [addr_width-1:0] col_a;

  // Decode of the incoming byte and the handshake.
  always_comb begin
    accept    = in_valid && in_ready;
    printable = (in_data >= CH_FIRST) && (in_data <= CH_LAST);
    col_a     = addr_width'(col);
  end

  // Clear sweep, byte interpretation, cursor tracking and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      cur_addr <= '0;
      col      <= '0;
      row      <= '0;
      write_en <= 1'b0;
      waddr    <= '0;
      din      <= '0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          write_en <= 1'b1;
          waddr    <= clr_cnt;
          din      <= BLANK;
          in_ready <= 1'b0;
          if (clr_cnt == LAST_ADDR) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ONE_A;
          end
        end

        IDLE: begin
          write_en <= 1'b0;
          in_ready <= 1'b1;
          if (accept) begin
            if (in_data == CH_CR) begin
              col      <= '0;
              cur_addr <= cur_addr - col_a;
            end else if (in_data == CH_LF) begin
              col <= '0;
              if (row == LAST_ROW) begin
                row      <= '0;
                cur_addr <= '0;
              end else begin
                row      <= row + ONE_R;
                cur_addr <= cur_addr - col_a + COLS_A;
              end
            end else if (in_data == CH_BS) begin
              // No reverse line wrap: backspace at column 0 does nothing.
              if (col != '0) begin
                col      <= col - ONE_C;
                cur_addr <= cur_addr - ONE_A;
                write_en <= 1'b1;
                waddr    <= cur_addr - ONE_A;
                din      <= BLANK;
              end
            end else if (in_data == CH_FF) begin
              // The first blank write goes out with the FF itself, so the sweep
              // continues from address 1.
              col      <= '0;
              row      <= '0;
              cur_addr <= '0;
              state    <= CLEAR;
              clr_cnt  <= ONE_A;
              in_ready <= 1'b0;
              write_en <= 1'b1;
              waddr    <= '0;
              din      <= BLANK;
            end else if (printable) begin
              write_en <= 1'b1;
              waddr    <= cur_addr;
              din      <= in_data;
              // Linear address steps by one except on the full-screen wrap.
              if (col == LAST_COL) begin
                col <= '0;
                if (row == LAST_ROW) begin
                  row      <= '0;
                  cur_addr <= '0;
                end else begin
                  row      <= row + ONE_R;
                  cur_addr <= cur_addr + ONE_A;
                end
              end else begin
                col      <= col + ONE_C;
                cur_addr <= cur_addr + ONE_A;
              end
            end
          end
        end

        default: state <= CLEAR;
      endcase
    end
  end

  // Cursor outputs are the cursor registers themselves.
  always_comb begin
    cursor_col = col;
    cursor_row = row;
  end

endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: randomized stream against a screen/cursor reference model.
module tb_text_writer;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int RAM  = COLS * ROWS;
  localparam int AW   = $clog2(RAM);
  localparam int W    = AW + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [7:0]    in_data  = 8'h00;
  logic          in_ready;
  logic          write_en;
  logic [AW-1:0] waddr;
  logic [7:0]    din;
  logic [6:0]    cursor_col;
  logic [5:0]    cursor_row;

  text_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .write_en   (write_en),
    .waddr      (waddr),
    .din        (din),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];       // expected {addr, data} writes in order
  logic [7:0]   m_screen[RAM];  // what the screen should hold
  logic [7:0]   fb[RAM];        // framebuffer as written by the DUT
  int           m_col = 0;
  int           m_row = 0;
  logic         e_we  = 1'b0;

  // The framebuffer memory on the write port.
  always @(posedge clk) if (write_en) fb[waddr] <= din;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rnd_print();
    return 8'($urandom_range(32, 126));
  endfunction

  task automatic put(input int a, input logic [7:0] v);
    m_screen[a] = v;
    exp_q.push_back({AW'(a), v});
  endtask

  task automatic model_blank();
    for (int i = 0; i < RAM; i++) m_screen[i] = 8'h20;
    m_col = 0;
    m_row = 0;
  endtask

  // Screen/cursor semantics of one accepted byte.
  task automatic model(input logic [7:0] d);
    case (d)
      8'h0D: m_col = 0;
      8'h0A: begin m_col = 0; m_row = (m_row + 1) % ROWS; end
      8'h08: if (m_col > 0) begin m_col--; put(m_row * COLS + m_col, 8'h20); end
      8'h0C: model_blank();
      default:
        if (d >= 8'h20 && d <= 8'h7E) begin
          put(m_row * COLS + m_col, d);
          m_col++;
          if (m_col == COLS) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_outputs();
    check_eq("write_en", write_en, e_we);
    if (write_en && exp_q.size() > 0) check_eq("write", {waddr, din}, exp_q.pop_front());
    check_eq("cursor", {cursor_row, cursor_col}, {6'(m_row), 7'(m_col)});
  endtask

  // One cycle: check what the previous cycle's byte produced, then drive the next.
  task automatic step(input logic v, input logic [7:0] d);
    int qs;
    @(negedge clk);
    check_outputs();
    in_valid = v;
    in_data  = v ? d : 8'($urandom_range(0, 255));
    qs = exp_q.size();
    if (v) begin
      check_eq("in_ready", in_ready, 1);
      model(d);
    end
    e_we = (exp_q.size() > qs);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("reset_vals", {write_en, waddr, din, in_ready, cursor_col, cursor_row}, 0);
    rst = 1'b0;
    model_blank();
    exp_q.delete();
    e_we = 1'b0;
  endtask

  // Follows a clear sweep cycle by cycle; stop_at>=0 returns once that address shows.
  task automatic check_clear(input int stop_at);
    for (int i = 0; i < RAM; i++) begin
      @(negedge clk);
      check_eq("clear", {write_en, waddr, din, in_ready}, {1'b1, AW'(i), 8'h20, 1'b0});
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rnd_print();
      if (i == stop_at) return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("clear_done", {write_en, in_ready}, 2'b01);
    check_eq("clear_cursor", {cursor_row, cursor_col}, 0);
    e_we = 1'b0;
  endtask

  task automatic screen_check(input string tag);
    int mism = 0;
    for (int i = 0; i < RAM; i++) if (fb[i] !== m_screen[i]) mism++;
    check_eq(tag, mism, 0);
  endtask

  task automatic send_ff_checked();
    step(1'b1, 8'h0C);
    check_clear(-1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] d;
    int r;

    // Reset and initial clear.
    assert_reset();
    check_clear(-1);

    // Back-to-back printable bytes.
    step(1'b1, 8'h41);
    step(1'b1, 8'h42);
    step(1'b0, 8'h00);
    check_eq("ab_cursor", {cursor_row, cursor_col}, {6'd0, 7'd2});

    // Row wrap: cursor to (79,0), then X at 79 and Y at 80.
    repeat (77) step(1'b1, rnd_print());
    step(1'b1, 8'h58);
    step(1'b1, 8'h59);
    step(1'b0, 8'h00);
    check_eq("row_wrap_cursor", {cursor_row, cursor_col}, {6'd1, 7'd1});

    // Form feed at (10,10).
    repeat (9) step(1'b1, 8'h0A);
    repeat (10) step(1'b1, rnd_print());
    step(1'b0, 8'h00);
    check_eq("ff_pos", {cursor_row, cursor_col}, {6'd10, 7'd10});
    send_ff_checked();

    // Control codes.
    step(1'b1, 8'h0A);
    step(1'b1, 8'h0A);
    repeat (5) step(1'b1, rnd_print());
    step(1'b1, 8'h0D);               // (5,2) -> (0,2)
    repeat (5) step(1'b1, rnd_print());
    step(1'b1, 8'h0A);               // (5,2) -> (0,3)
    repeat (3) step(1'b1, rnd_print());
    step(1'b1, 8'h08);               // (3,3): blank at 242, -> (2,3)
    step(1'b0, 8'h00);
    check_eq("bs_cursor", {cursor_row, cursor_col}, {6'd3, 7'd2});
    step(1'b1, 8'h0D);
    step(1'b1, 8'h08);               // column 0: nothing
    step(1'b1, 8'h01);               // ignored
    step(1'b0, 8'h00);
    check_eq("bs_col0", {write_en, cursor_row, cursor_col}, {1'b0, 6'd3, 7'd0});

    // Screen wrap: 4799 chars, then Z lands on 4799 and the next on 0.
    send_ff_checked();
    repeat (RAM - 1) step(1'b1, rnd_print());
    step(1'b1, 8'h5A);
    step(1'b0, 8'h00);
    check_eq("wrap_cursor", {cursor_row, cursor_col}, 0);
    step(1'b1, rnd_print());
    step(1'b0, 8'h00);

    // Random stream with gaps; every control code except FF.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: d = 8'h0D;
        1: d = 8'h0A;
        2, 3: d = 8'h08;
        4: d = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'($urandom_range(127, 255));
        default: d = rnd_print();
      endcase
      step(1'($urandom_range(0, 3) != 0), d);
    end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    screen_check("screen_random");
    check_eq("queue_empty", exp_q.size(), 0);

    // Reset mid-stream.
    repeat (25) step(1'b1, rnd_print());
    assert_reset();
    check_clear(-1);

    // FF at (10,10), then reset part way through the clear.
    repeat (10) step(1'b1, 8'h0A);
    repeat (10) step(1'b1, rnd_print());
    step(1'b1, 8'h0C);
    check_clear(1000);
    assert_reset();
    check_clear(-1);
    step(1'b1, 8'h51);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    screen_check("screen_final");
    check_eq("queue_final", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_writer.md
# text_writer

Write-side client for the dual-port text framebuffer. Accepts a stream of ASCII bytes over a valid/ready handshake, keeps a character cursor, and drives the framebuffer write port (`write_en`/`waddr`/`din`), interpreting a small set of control codes. On reset and on form feed it blanks the whole screen. The display reader consumes the same memory on the other port.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 60, rows per screen
- `data_width`, 8, character code width
- `ram_size`, COLS*ROWS, framebuffer depth
- `addr_width`, $clog2(ram_size), framebuffer address width
- `BLANK`, 8'h20, fill code for clear and backspace
- `clk`  in  1  single clock; also drives the framebuffer write clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_data` is valid
- `in_data`  in  data_width  ASCII byte
- `in_ready`  out  1  block can accept a byte this cycle
- `write_en`  out  1  framebuffer write strobe
- `waddr`  out  addr_width  framebuffer write address
- `din`  out  data_width  framebuffer write data
- `cursor_col`  out  $clog2(COLS)  current column
- `cursor_row`  out  $clog2(ROWS)  current row

## Operation
- Two states: CLEAR and IDLE. All outputs are registered.
- CLEAR: writes `BLANK` to addresses 0..ram_size-1, one per cycle, in ascending order. `in_ready`=0. After the write to ram_size-1, go to IDLE.
- IDLE: `in_ready`=1. A byte is accepted on any edge where `in_valid && in_ready`. Throughput is one byte per cycle.
- Cursor linear address `row*COLS+col` is maintained incrementally. No multiplier.
- Printable 0x20..0x7E: write the byte at the cursor address, then advance the cursor.
  - Advance: col+1.
  - If col==COLS-1: col=0 and row+1.
  - If the row was ROWS-1: row wraps to 0, so the address wraps 4799 -> 0. There is no scrolling.
- 0x0D (CR): col=0. No write.
- 0x0A (LF): col=0 and row+1, with wrap. No write.
- 0x08 (BS):
  - If col>0: col-1, and write `BLANK` at the new position.
  - At col 0: no change, no write. There is no reverse line wrap.
- 0x0C (FF): cursor goes to (0,0) and the block enters CLEAR.
- Any other byte is accepted and ignored. No write, no cursor change.

## Timing
- Reset values: `write_en`=0, `waddr`=0, `din`=0, `in_ready`=0, cursor (0,0), state CLEAR with clear counter 0.
- Clear timing:
  - Let C be the first cycle with `rst`=0.
  - During cycles C..C+ram_size-1: `write_en`=1, `din`=`BLANK`, `waddr`=cycle-C.
  - During cycle C+ram_size: `write_en`=0 and `in_ready`=1.
- Byte accepted at edge t:
  - In the cycle after t: `write_en`=1 (printable/BS only), `waddr` = the target address, `din` = the byte or `BLANK`.
  - The cursor outputs show the post-update value in that same cycle.
  - `write_en` returns to 0 the following cycle unless another write-causing byte was accepted.
- FF accepted at edge t:
  - `in_ready`=0 from the cycle after t.
  - The clear writes occupy the next ram_size cycles, starting at `waddr`=0.
  - `in_ready`=1 again ram_size+1 cycles after t.
- `rst` asserted mid-clear or mid-stream: all work is abandoned, the reset values apply, and the clear restarts from address 0.
- `in_valid` with `in_ready`=0: the byte is not consumed. The source must hold it. `in_data` is don't-care when `in_valid`=0.

## Test plan
- Reset, then idle: exactly 4800 consecutive writes with `din`=0x20 and `waddr` 0..4799; `in_ready` rises the next cycle; cursor (0,0).
- Send "A","B" back-to-back: writes (0,0x41) then (1,0x42) on consecutive cycles; cursor (2,0).
- Row wrap: place the cursor at (79,0) using 79 printable bytes, then send "X": write to addr 79; cursor (0,1); the next "Y" writes addr 80.
- Screen wrap: fill 4799 chars, then send "Z": write to addr 4799; cursor (0,0); the next char writes addr 0.
- Control codes:
  - At (5,2): CR gives (0,2) with no write.
  - From (5,2), LF gives (0,3) with no write.
  - BS at (3,3): write (0x20 at addr 242), cursor (2,3).
  - BS at col 0: no write, no cursor change.
  - Byte 0x01: ignored.
- FF, and reset during clear:
  - FF at cursor (10,10): `in_ready` low, 4800 blank writes from addr 0, cursor (0,0).
  - `rst` pulsed at clear address 1000: the clear restarts at addr 0 and completes 4800 writes.
